// File: rtl/emailbox_tx.sv
// Mailbox transmit side: queues 64-bit messages from the register port
// and emits emesh write packets to a remote MAILBOXLO through a wait-aware stage.
module emailbox_tx #(
  parameter int          AW       = 32,
  parameter int          PW       = 2*AW+40,
  parameter int          RFAW     = 6,
  parameter int          DEPTH    = 4,
  parameter int          CW       = $clog2(DEPTH)+1,
  parameter logic [11:0] DEST_RST = 12'h000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reg_access,
  input  logic [PW-1:0] reg_packet,
  output logic [31:0]   reg_rdata,
  output logic          access_out,
  output logic [PW-1:0] packet_out,
  input  logic          wait_in,
  input  logic          tx_irq_en,
  output logic          tx_irq,
  output logic          tx_wait
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int MW   = 12 + 64;

  localparam logic [RFAW-1:0] TXLO   = RFAW'('h8);
  localparam logic [RFAW-1:0] TXHI   = RFAW'('h9);
  localparam logic [RFAW-1:0] TXDEST = RFAW'('hA);
  localparam logic [RFAW-1:0] TXSTAT = RFAW'('hB);

  logic            reg_write;
  logic [AW-1:0]   reg_dstaddr;
  logic [AW-1:0]   reg_data;
  logic [RFAW-1:0] reg_addr;
  logic            unused_ok;

  assign reg_write   = reg_packet[0];
  assign reg_dstaddr = reg_packet[AW+7:8];
  assign reg_data    = reg_packet[2*AW+7:AW+8];
  assign reg_addr    = reg_dstaddr[RFAW+1:2];
  assign unused_ok   = ^{reg_packet[7:1],
                         reg_packet[PW-1:2*AW+8],
                         reg_dstaddr[1:0],
                         reg_dstaddr[AW-1:RFAW+2]};

  logic wr_lo, wr_hi, wr_dest, wr_stat, rd_stat, rd_any;

  assign wr_lo   = reg_access & reg_write & (reg_addr == TXLO);
  assign wr_hi   = reg_access & reg_write & (reg_addr == TXHI);
  assign wr_dest = reg_access & reg_write & (reg_addr == TXDEST);
  assign wr_stat = reg_access & reg_write & (reg_addr == TXSTAT);
  assign rd_any  = reg_access & ~reg_write;
  assign rd_stat = rd_any & (reg_addr == TXSTAT);

  logic [MW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     hi_reg;
  logic [11:0]     dest;
  logic            overflow;
  logic            full, empty, push, pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // full is judged before any same-cycle pop, so a push at full always drops
  assign push  = wr_lo & ~full;
  assign pop   = ~empty & (~access_out | ~wait_in);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dest, hi_reg, reg_data[31:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg   <= '0;
      dest     <= DEST_RST;
      overflow <= 1'b0;
    end else begin
      if (wr_hi)   hi_reg <= reg_data[31:0];
      if (wr_dest) dest   <= reg_data[11:0];
      if (wr_lo & full)
        overflow <= 1'b1;
      else if (wr_stat & reg_data[2])
        overflow <= 1'b0;
    end
  end

  logic [MW-1:0] head;
  logic [31:0]   head_dst;
  logic [PW-1:0] pkt_next;

  assign head     = mem[rd_ptr];
  assign head_dst = {head[75:64], 4'hF, 5'b0, 3'h7, 6'hC, 2'b00};

  always_comb begin
    pkt_next                   = '0;
    pkt_next[0]                = 1'b1;
    pkt_next[2:1]              = 2'b11;
    pkt_next[AW+7:8]           = AW'(head_dst);
    pkt_next[2*AW+7:AW+8]      = AW'(head[31:0]);
    pkt_next[3*AW+7:2*AW+8]    = AW'(head[63:32]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      access_out <= 1'b0;
      packet_out <= '0;
    end else if (pop) begin
      access_out <= 1'b1;
      packet_out <= pkt_next;
    end else if (access_out & ~wait_in) begin
      access_out <= 1'b0;
    end
  end

  logic [31:0] status;

  assign status = {16'(count), 12'h0, access_out, overflow, full, ~empty};

  always_ff @(posedge clk) begin
    if (reset)        reg_rdata <= '0;
    else if (rd_stat) reg_rdata <= status;
    else              reg_rdata <= '0;
  end

  assign tx_irq  = tx_irq_en & empty & ~access_out;
  assign tx_wait = full;

endmodule
